// File: rtl/uart_frame_parser.sv
// Extracts SYNC/LEN/payload/XOR-checksum frames from the UART RX word stream.
// All outputs registered, one cycle after the causing word; no back-pressure.
module uart_frame_parser #(
  parameter int                   DATA_BITS      = 8,
  parameter int                   MAX_PAYLOAD    = 16,
  parameter logic [DATA_BITS-1:0] SYNC_WORD      = DATA_BITS'(8'hAA),
  parameter int                   TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_valid,
  output logic [DATA_BITS-1:0] payload_data,
  output logic                 payload_valid,
  output logic [((MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1)-1:0] payload_index,
  output logic                 frame_done,
  output logic                 frame_error,
  output logic [1:0]           error_code,
  output logic                 busy
);

  localparam int IW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [DATA_BITS-1:0] MAXLEN = DATA_BITS'(MAX_PAYLOAD);

  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CHKSUM} state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] len_q, len_d;
  logic [DATA_BITS-1:0] csum_q, csum_d;
  logic [IW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [DATA_BITS-1:0] pdata_q, pdata_d;
  logic [IW-1:0]        pidx_q, pidx_d;
  logic                 pvld_q, pvld_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;
  logic                 timeout_hit;

  // Expiry only counts on a cycle with no word; an arriving word always wins.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q != IDLE) && !rx_valid &&
                       (timer_q == TLAST);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    csum_d  = csum_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    pdata_d = pdata_q;
    pidx_d  = pidx_q;
    code_d  = code_q;
    pvld_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (rx_valid && rx_data == SYNC_WORD) state_d = LEN;
      end
      LEN: begin
        if (rx_valid) begin
          if (rx_data == '0 || rx_data > MAXLEN) begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = IDLE;
          end else begin
            len_d   = rx_data;
            csum_d  = rx_data;
            cnt_d   = '0;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          pvld_d  = 1'b1;
          pdata_d = rx_data;
          pidx_d  = cnt_q;
          csum_d  = csum_q ^ rx_data;
          cnt_d   = cnt_q + 1'b1;
          if (DATA_BITS'(cnt_q) == len_q - 1'b1) state_d = CHKSUM;
        end
      end
      default: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = 2'b10;
          end
          state_d = IDLE;
        end
      end
    endcase

    if (state_q != IDLE) begin
      if (rx_valid) begin
        timer_d = '0;
      end else if (timeout_hit) begin
        err_d   = 1'b1;
        code_d  = 2'b11;
        state_d = IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      csum_q  <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      pdata_q <= '0;
      pidx_q  <= '0;
      pvld_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      pdata_q <= pdata_d;
      pidx_q  <= pidx_d;
      pvld_q  <= pvld_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign payload_data  = pdata_q;
  assign payload_valid = pvld_q;
  assign payload_index = pidx_q;
  assign frame_done    = done_q;
  assign frame_error   = err_q;
  assign error_code    = code_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: frame-level reference model plus literal checks.
module tb_uart_frame_parser;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] payload_data;
  logic       payload_valid;
  logic [3:0] payload_index;
  logic       frame_done;
  logic       frame_error;
  logic [1:0] error_code;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  uart_frame_parser #(
    .DATA_BITS(8), .MAX_PAYLOAD(16), .SYNC_WORD(8'hAA), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .payload_data(payload_data), .payload_valid(payload_valid),
    .payload_index(payload_index), .frame_done(frame_done),
    .frame_error(frame_error), .error_code(error_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: keeps the words seen since SYNC and decides from their positions.
  logic       m_in_frame = 1'b0;
  logic [7:0] m_fr[$];
  int         m_idle = 0;
  logic       e_pv = 0, e_done = 0, e_err = 0, e_busy = 0;
  logic [7:0] e_pd = 0;
  logic [3:0] e_pi = 0;
  logic [1:0] e_code = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_in_frame = 0; m_fr.delete(); m_idle = 0;
      e_pv = 0; e_done = 0; e_err = 0; e_busy = 0; e_pd = 0; e_pi = 0; e_code = 0;
    end else begin
      e_pv = 0; e_done = 0; e_err = 0;
      if (!m_in_frame) begin
        if (rx_valid && rx_data == 8'hAA) begin
          m_in_frame = 1; m_fr.delete(); m_idle = 0;
        end
      end else if (rx_valid) begin
        int n;
        m_idle = 0;
        m_fr.push_back(rx_data);
        n = m_fr.size();
        if (n == 1) begin
          if (rx_data == 0 || rx_data > 16) begin
            e_err = 1; e_code = 2'b01; m_in_frame = 0;
          end
        end else if (n <= int'(m_fr[0]) + 1) begin
          e_pv = 1; e_pd = rx_data; e_pi = 4'(n - 2);
        end else begin
          logic [7:0] x;
          x = 0;
          for (int i = 0; i < n - 1; i++) x ^= m_fr[i];
          if (x == rx_data) e_done = 1;
          else begin e_err = 1; e_code = 2'b10; end
          m_in_frame = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          e_err = 1; e_code = 2'b11; m_in_frame = 0;
        end
      end
      e_busy = m_in_frame;
    end
  end

  logic [7:0] plog[$];
  int n_done = 0, n_err = 0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("payload_valid", payload_valid, e_pv);
      chk("frame_done", frame_done, e_done);
      chk("frame_error", frame_error, e_err);
      chk("error_code", error_code, e_code);
      chk("busy", busy, e_busy);
      if (e_pv) begin
        chk("payload_data", payload_data, e_pd);
        chk("payload_index", payload_index, e_pi);
      end
      if (payload_valid) plog.push_back(payload_data);
      if (frame_done) n_done++;
      if (frame_error) n_err++;
    end
  end

  task automatic word(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk); #1;
  endtask

  task automatic gap(input int n);
    rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr();
    plog.delete(); n_done = 0; n_err = 0;
  endtask

  task automatic tally(input string nm, input int done, input int err, input logic [1:0] code);
    chk({nm, " done count"}, n_done, done);
    chk({nm, " error count"}, n_err, err);
    chk({nm, " held error_code"}, error_code, code);
  endtask

  task automatic plog_is(input string nm, input logic [7:0] a[$]);
    chk({nm, " payload count"}, plog.size(), a.size());
    if (plog.size() == a.size())
      foreach (a[i]) chk({nm, " payload word"}, plog[i], a[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    #12;
    chk("reset payload_valid", payload_valid, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset frame_error", frame_error, 0);
    chk("reset error_code", error_code, 0);
    chk("reset busy", busy, 0);
    @(posedge clk); #1; reset = 1'b0;
    gap(2);

    clr();
    word(8'hAA); word(8'h03); word(8'h11); word(8'h22); word(8'h33); word(8'h03); gap(2);
    tally("good frame", 1, 0, 2'b00);
    plog_is("good frame", '{8'h11, 8'h22, 8'h33});

    clr();
    word(8'hAA); word(8'h02); word(8'h10); word(8'h20); word(8'hFF); gap(2);
    tally("bad checksum", 0, 1, 2'b10);
    plog_is("bad checksum", '{8'h10, 8'h20});
    chk("bad checksum busy", busy, 0);

    clr();
    word(8'hAA); word(8'h00); gap(1);
    word(8'hAA); word(8'h11); gap(1);
    tally("bad len", 0, 2, 2'b01);
    chk("bad len payload count", plog.size(), 0);
    clr();
    word(8'hAA); word(8'h01); word(8'h5A); word(8'h5B); gap(2);
    tally("after bad len", 1, 0, 2'b01);

    clr();
    word(8'hAA); word(8'h02); word(8'h10); gap(TO); gap(2);
    tally("timeout", 0, 1, 2'b11);
    clr();
    word(8'hAA); word(8'h02); word(8'h10); gap(TO - 1); word(8'h20); word(8'h32); gap(2);
    tally("word at expiry", 1, 0, 2'b11);
    plog_is("word at expiry", '{8'h10, 8'h20});

    clr();
    word(8'h55); word(8'hAA); word(8'h01); word(8'hAA); word(8'hAB); gap(2);
    tally("sync as payload", 1, 0, 2'b11);
    plog_is("sync as payload", '{8'hAA});
    clr();
    word(8'h55); word(8'hAA); word(8'hAA); word(8'h01); word(8'hAA); word(8'hAA); gap(2);
    tally("sync as len", 0, 2, 2'b01);

    clr();
    word(8'hAA); word(8'h03); word(8'h11);
    reset = 1'b1; rx_valid = 1'b0;
    #1;
    chk("mid reset payload_valid", payload_valid, 0);
    chk("mid reset payload_data", payload_data, 0);
    chk("mid reset payload_index", payload_index, 0);
    chk("mid reset error_code", error_code, 0);
    chk("mid reset busy", busy, 0);
    @(posedge clk); #1; reset = 1'b0;
    clr();
    gap(2);
    word(8'hAA); word(8'h02); word(8'h01); word(8'h02); word(8'h01); gap(2);
    tally("after reset", 1, 0, 2'b00);
    plog_is("after reset", '{8'h01, 8'h02});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
